// File: rtl/axi_pkg.sv
// Shared AXI4 widths, burst/response encodings and FSM states for the RAM responder.
package axi_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // One-hot-ish encodings so each ready/valid is a plain state flop.
    typedef enum logic [2:0] {
        W_RST  = 3'b000,
        W_IDLE = 3'b001,
        W_DATA = 3'b010,
        W_RESP = 3'b100
    } wstate_t;

    typedef enum logic [1:0] {
        R_RST  = 2'b00,
        R_IDLE = 2'b01,
        R_DATA = 2'b10
    } rstate_t;

    // Codes are ordered by severity, so the worst response is the numeric max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address for FIXED / INCR / WRAP bursts; combinational, no latency.
// Illegal WRAP lengths and the reserved burst code step as INCR.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W-1:0] size,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_ok;

    always_comb begin
        step      = 32'd1 << size;
        incr      = addr + step;
        wrap_ok   = (burst == BURST_WRAP) &&
                    (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        next_addr = incr;
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (wrap_ok)
            next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
    end
endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 slave over a 64-bit byte-writable RAM; reads return beat 0 one cycle after AR.
// Independent read/write FSMs, one beat per cycle each; R and B hold until rready/bready.
module axi_ram_responder
    import axi_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ID_W-1:0]   SAXI_awid,
    input  logic [ADDR_W-1:0] SAXI_awaddr,
    input  logic [LEN_W-1:0]  SAXI_awlen,
    input  logic [SIZE_W-1:0] SAXI_awsize,
    input  logic [1:0]        SAXI_awburst,
    input  logic              SAXI_awvalid,
    output logic              SAXI_awready,
    input  logic [DATA_W-1:0] SAXI_wdata,
    input  logic [STRB_W-1:0] SAXI_wstrb,
    input  logic              SAXI_wlast,
    input  logic              SAXI_wvalid,
    output logic              SAXI_wready,
    output logic [ID_W-1:0]   SAXI_bid,
    output logic [1:0]        SAXI_bresp,
    output logic              SAXI_bvalid,
    input  logic              SAXI_bready,
    input  logic [ID_W-1:0]   SAXI_arid,
    input  logic [ADDR_W-1:0] SAXI_araddr,
    input  logic [LEN_W-1:0]  SAXI_arlen,
    input  logic [SIZE_W-1:0] SAXI_arsize,
    input  logic [1:0]        SAXI_arburst,
    input  logic              SAXI_arvalid,
    output logic              SAXI_arready,
    output logic [ID_W-1:0]   SAXI_rid,
    output logic [DATA_W-1:0] SAXI_rdata,
    output logic [1:0]        SAXI_rresp,
    output logic              SAXI_rlast,
    output logic              SAXI_rvalid,
    input  logic              SAXI_rready
);
    localparam logic [63:0] SPAN = 64'd8 << DEPTH_LOG2;

    logic [DATA_W-1:0] ram [0:(2**DEPTH_LOG2)-1];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ({32'd0, a - BASE_ADDR} < SPAN);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 3);
    endfunction

    // ---------------- write channel ----------------
    wstate_t           wstate, wstate_nxt;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt;
    logic [LEN_W-1:0]  wlen_q, wcnt_q;
    logic [SIZE_W-1:0] wsize_q;
    logic [1:0]        wburst_q, wacc_q, wbeat_resp;
    logic              wbeat, wlast_beat, whit;

    assign wbeat      = (wstate == W_DATA) && SAXI_wvalid;
    assign wlast_beat = (wcnt_q == wlen_q);
    assign whit       = in_range(waddr_q);
    assign wbeat_resp = resp_max(whit ? RESP_OKAY : RESP_DECERR,
                                 (SAXI_wlast == wlast_beat) ? RESP_OKAY : RESP_SLVERR);

    axi_burst_addr u_wr_addr (
        .addr      (waddr_q),
        .size      (wsize_q),
        .len       (wlen_q),
        .burst     (wburst_q),
        .next_addr (waddr_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wstate <= W_RST;
        else        wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_RST:  wstate_nxt = W_IDLE;
            W_IDLE: if (SAXI_awvalid)          wstate_nxt = W_DATA;
            W_DATA: if (wbeat && wlast_beat)   wstate_nxt = W_RESP;
            W_RESP: if (SAXI_bready)           wstate_nxt = W_IDLE;
            default:                           wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        SAXI_awready = (wstate == W_IDLE);
        SAXI_wready  = (wstate == W_DATA);
        SAXI_bvalid  = (wstate == W_RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            SAXI_bid   <= '0;
            SAXI_bresp <= RESP_OKAY;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wcnt_q     <= '0;
            wacc_q     <= RESP_OKAY;
        end else begin
            if (SAXI_awvalid && SAXI_awready) begin
                SAXI_bid <= SAXI_awid;
                waddr_q  <= SAXI_awaddr;
                wlen_q   <= SAXI_awlen;
                wsize_q  <= SAXI_awsize;
                wburst_q <= SAXI_awburst;
                wcnt_q   <= '0;
                wacc_q   <= RESP_OKAY;
            end
            if (wbeat) begin
                waddr_q <= waddr_nxt;
                wcnt_q  <= wcnt_q + 8'd1;
                wacc_q  <= resp_max(wacc_q, wbeat_resp);
                if (wlast_beat)
                    SAXI_bresp <= resp_max(wacc_q, wbeat_resp);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wbeat && whit) begin
            for (int b = 0; b < STRB_W; b++)
                if (SAXI_wstrb[b])
                    ram[word_idx(waddr_q)][b*8 +: 8] <= SAXI_wdata[b*8 +: 8];
        end
    end

    // ---------------- read channel ----------------
    rstate_t           rstate, rstate_nxt;
    logic [ADDR_W-1:0] raddr_q, raddr_nxt, rd_addr;
    logic [LEN_W-1:0]  rlen_q, rcnt_q;
    logic [SIZE_W-1:0] rsize_q;
    logic [1:0]        rburst_q;
    logic              arhs, rhs, rlast_beat, rload, rd_hit;

    assign arhs       = SAXI_arvalid && SAXI_arready;
    assign rhs        = SAXI_rvalid && SAXI_rready;
    assign rlast_beat = (rcnt_q == rlen_q);
    assign rload      = arhs || (rhs && !rlast_beat);
    assign rd_addr    = arhs ? SAXI_araddr : raddr_nxt;
    assign rd_hit     = in_range(rd_addr);

    axi_burst_addr u_rd_addr (
        .addr      (raddr_q),
        .size      (rsize_q),
        .len       (rlen_q),
        .burst     (rburst_q),
        .next_addr (raddr_nxt)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rstate <= R_RST;
        else        rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_RST:  rstate_nxt = R_IDLE;
            R_IDLE: if (SAXI_arvalid)               rstate_nxt = R_DATA;
            R_DATA: if (SAXI_rready && rlast_beat)  rstate_nxt = R_IDLE;
            default:                                rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        SAXI_arready = (rstate == R_IDLE);
        SAXI_rvalid  = (rstate == R_DATA);
    end

    // The RAM is sampled when a beat is loaded, so a same-edge write is not seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            SAXI_rid   <= '0;
            SAXI_rdata <= '0;
            SAXI_rresp <= RESP_OKAY;
            SAXI_rlast <= 1'b0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rcnt_q     <= '0;
        end else begin
            if (arhs) begin
                SAXI_rid   <= SAXI_arid;
                raddr_q    <= SAXI_araddr;
                rlen_q     <= SAXI_arlen;
                rsize_q    <= SAXI_arsize;
                rburst_q   <= SAXI_arburst;
                rcnt_q     <= '0;
                SAXI_rlast <= (SAXI_arlen == 8'd0);
            end else if (rhs && !rlast_beat) begin
                raddr_q    <= raddr_nxt;
                rcnt_q     <= rcnt_q + 8'd1;
                SAXI_rlast <= ((rcnt_q + 8'd1) == rlen_q);
            end
            if (rload) begin
                SAXI_rdata <= rd_hit ? ram[word_idx(rd_addr)] : '0;
                SAXI_rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
            end
        end
    end
endmodule
